// File: rtl/vram_hdma.sv
// ---------------------------------------------------------------------------
// vram_hdma -- CGB-style VRAM DMA controller (HDMA1..HDMA5 at FF51..FF55).
//
// Copies 16-byte blocks from the ext/WRAM source bus into VRAM, either as a
// single general-purpose burst (GDMA) or one block per HBlank entry (HDMA).
// While bytes are moving the engine owns the relevant bus through the occupy
// flags and holds the CPU at its M-cycle boundary.
//
// Optional feature: define VRAM_HDMA_HBLANK_EN to enable HBlank mode (HWAIT
// state, hblank input). Without it, every FF55 start runs as GDMA and the
// hblank input is ignored.
//
// Ports:
//   clk, rst          system clock, asynchronous active-high reset
//   ct                T-cycle index within the CPU M-cycle
//   mmio_a/din/wr/rd  CPU register access (wr pre-decoded to FF51..FF55)
//   mmio_dout         register read data (HDMA1..4 read FF)
//   hblank            PPU mode-0 level
//   src_a/rd/din      source bus; src_din is valid the cycle after src_rd
//   vram_a/dout/wr    VRAM write port
//   occupy_extbus     engine owns the ext/WRAM bus (read phase)
//   occupy_vidbus     engine owns the VRAM bus (write phase)
//   cpu_stall         hold CPU while a burst/block is being moved
//   busy              transfer pending or active
// ---------------------------------------------------------------------------
module vram_hdma #(
    parameter int unsigned BYTE_CYCLES = 2,
    parameter logic [15:0] MMIO_BASE   = 16'hFF51
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [1:0]  ct,
    input  logic [15:0] mmio_a,
    input  logic [7:0]  mmio_din,
    input  logic        mmio_wr,
    input  logic        mmio_rd,
    output logic [7:0]  mmio_dout,
    input  logic        hblank,
    output logic [15:0] src_a,
    output logic        src_rd,
    input  logic [7:0]  src_din,
    output logic [15:0] vram_a,
    output logic [7:0]  vram_dout,
    output logic        vram_wr,
    output logic        occupy_extbus,
    output logic        occupy_vidbus,
    output logic        cpu_stall,
    output logic        busy
);

    typedef enum logic [2:0] {
        IDLE,
        ALIGN,
        XFER_RD,
        XFER_WR
`ifdef VRAM_HDMA_HBLANK_EN
        , HWAIT
`endif
    } state_t;

    // With 4 clk per byte each phase is held one extra cycle.
    localparam logic LONG_PHASE = (BYTE_CYCLES == 4);

    state_t      state;
    logic [15:4] src_reg;      // HDMA1/2, low nibble implicitly 0
    logic [12:4] dst_reg;      // HDMA3/4, only bits 12:4 exist
    logic [15:0] src_ptr;      // running counters, loaded at each start
    logic [12:0] dst_ptr;
    logic [6:0]  remaining;    // blocks left minus 1
    logic [3:0]  byte_idx;     // byte within the current block
    logic        sub;          // second cycle of a held phase
    logic        hdma_mode;
    logic        cancel_pend;  // cancel seen while a block was in flight
    logic [13:0] dst_nxt;

    logic wr_hdma1, wr_hdma2, wr_hdma3, wr_hdma4, wr_hdma5;
    logic cancel_req;

    assign wr_hdma1 = mmio_wr && (mmio_a == MMIO_BASE);
    assign wr_hdma2 = mmio_wr && (mmio_a == MMIO_BASE + 16'd1);
    assign wr_hdma3 = mmio_wr && (mmio_a == MMIO_BASE + 16'd2);
    assign wr_hdma4 = mmio_wr && (mmio_a == MMIO_BASE + 16'd3);
    assign wr_hdma5 = mmio_wr && (mmio_a == MMIO_BASE + 16'd4);

    // Only a running HDMA can be cancelled; GDMA keeps the CPU stalled.
    assign cancel_req = wr_hdma5 && !mmio_din[7] && hdma_mode;

    // Bit 13 is the carry out of the 13-bit VRAM offset.
    assign dst_nxt = {1'b0, dst_ptr} + 14'd1;

`ifdef VRAM_HDMA_HBLANK_EN
    logic hblank_q;
    logic hblank_rise;
    assign hblank_rise = hblank && !hblank_q;
`else
    logic unused_hblank;
    assign unused_hblank = hblank;
`endif

    // Addresses and data are only presented during their own phase.
    assign src_a     = src_rd  ? src_ptr : 16'h0000;
    assign vram_a    = vram_wr ? (16'h8000 | {3'b000, dst_ptr}) : 16'h0000;
    assign vram_dout = vram_wr ? src_din : 8'h00;

    assign mmio_dout = (mmio_rd && (mmio_a == MMIO_BASE + 16'd4))
                     ? {~(busy && hdma_mode), remaining}
                     : 8'hFF;

    // NOTE: all state and registered outputs use non-blocking assignments so
    // every branch below sees the values from before this clock edge.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state         <= IDLE;
            src_reg       <= '0;
            dst_reg       <= '0;
            src_ptr       <= '0;
            dst_ptr       <= '0;
            remaining     <= 7'h7F;
            byte_idx      <= '0;
            sub           <= 1'b0;
            hdma_mode     <= 1'b0;
            cancel_pend   <= 1'b0;
            src_rd        <= 1'b0;
            vram_wr       <= 1'b0;
            occupy_extbus <= 1'b0;
            occupy_vidbus <= 1'b0;
            cpu_stall     <= 1'b0;
            busy          <= 1'b0;
`ifdef VRAM_HDMA_HBLANK_EN
            hblank_q      <= 1'b0;
`endif
        end else begin
`ifdef VRAM_HDMA_HBLANK_EN
            hblank_q <= hblank;
`endif
            // Register writes never touch the running counters.
            if (wr_hdma1) src_reg[15:8] <= mmio_din;
            if (wr_hdma2) src_reg[7:4]  <= mmio_din[7:4];
            if (wr_hdma3) dst_reg[12:8] <= mmio_din[4:0];
            if (wr_hdma4) dst_reg[7:4]  <= mmio_din[7:4];

            case (state)
                IDLE: begin
                    if (wr_hdma5) begin
                        remaining   <= mmio_din[6:0];
                        src_ptr     <= {src_reg, 4'h0};
                        dst_ptr     <= {dst_reg, 4'h0};
                        byte_idx    <= '0;
                        sub         <= 1'b0;
                        cancel_pend <= 1'b0;
                        busy        <= 1'b1;
`ifdef VRAM_HDMA_HBLANK_EN
                        hdma_mode   <= mmio_din[7];
                        state       <= mmio_din[7] ? HWAIT : ALIGN;
`else
                        hdma_mode   <= 1'b0;
                        state       <= ALIGN;
`endif
                    end
                end

                ALIGN: begin
                    if (cancel_req) begin
                        state     <= IDLE;
                        busy      <= 1'b0;
                        hdma_mode <= 1'b0;
                    end else if (ct == 2'd3) begin
                        // Next cycle is T0 of a fresh M-cycle.
                        state         <= XFER_RD;
                        src_rd        <= 1'b1;
                        occupy_extbus <= 1'b1;
                        cpu_stall     <= 1'b1;
                    end
                end

                XFER_RD: begin
                    if (cancel_req) cancel_pend <= 1'b1;
                    if (sub == LONG_PHASE) begin
                        sub           <= 1'b0;
                        state         <= XFER_WR;
                        src_rd        <= 1'b0;
                        occupy_extbus <= 1'b0;
                        vram_wr       <= 1'b1;
                        occupy_vidbus <= 1'b1;
                    end else begin
                        sub <= 1'b1;
                    end
                end

                XFER_WR: begin
                    if (cancel_req) cancel_pend <= 1'b1;
                    if (sub == LONG_PHASE) begin
                        sub           <= 1'b0;
                        vram_wr       <= 1'b0;
                        occupy_vidbus <= 1'b0;
                        src_ptr       <= src_ptr + 16'd1;
                        dst_ptr       <= dst_nxt[12:0];
                        byte_idx      <= byte_idx + 4'd1;
                        if (byte_idx == 4'hF && (remaining == 7'd0 || dst_nxt[13]
                                                 || cancel_pend || cancel_req)) begin
                            // Completion, VRAM wrap or cancel: stop at block end.
                            remaining <= dst_nxt[13] ? 7'h7F : remaining - 7'd1;
                            state     <= IDLE;
                            busy      <= 1'b0;
                            cpu_stall <= 1'b0;
                            hdma_mode <= 1'b0;
`ifdef VRAM_HDMA_HBLANK_EN
                        end else if (byte_idx == 4'hF && hdma_mode) begin
                            remaining <= remaining - 7'd1;
                            state     <= HWAIT;
                            cpu_stall <= 1'b0;
`endif
                        end else begin
                            if (byte_idx == 4'hF) remaining <= remaining - 7'd1;
                            state         <= XFER_RD;
                            src_rd        <= 1'b1;
                            occupy_extbus <= 1'b1;
                        end
                    end else begin
                        sub <= 1'b1;
                    end
                end

`ifdef VRAM_HDMA_HBLANK_EN
                HWAIT: begin
                    // A cancel in the same cycle as the edge wins.
                    if (cancel_req) begin
                        state     <= IDLE;
                        busy      <= 1'b0;
                        hdma_mode <= 1'b0;
                    end else if (hblank_rise) begin
                        state <= ALIGN;
                    end
                end
`endif

                default: state <= IDLE;
            endcase
        end
    end

endmodule
